// File: rtl/counter_pkg.sv
// Shared types for the multi_counter bank: per-channel run-mode encoding.
package counter_pkg;

    localparam int CNT_MODE_W = 2;

    typedef enum logic [CNT_MODE_W-1:0] {
        CNT_DOWN_SAT    = 2'd0,
        CNT_DOWN_RELOAD = 2'd1,
        CNT_UP_WRAP     = 2'd2,
        CNT_UP_SAT      = 2'd3
    } cnt_mode_t;

endpackage

// File: rtl/counter_channel.sv
// One loadable counter channel: count/limit/tc registers plus mode-dependent step logic.
// term is the combinational "this step hits the terminal condition" flag used for chaining.
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             step_en,
    input  logic             set,
    input  logic             clear,
    input  logic [WIDTH-1:0] set_val,
    input  cnt_mode_t        mode,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] limit,
    output logic             tc,
    output logic             term
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] limit_r;
    logic             tc_r;
    logic             step_s;
    logic             hit_s;
    logic [WIDTH-1:0] step_count_s;

    assign step_s = step_en & ~set & ~clear;
    assign term   = step_s & hit_s;
    assign count  = count_r;
    assign limit  = limit_r;
    assign tc     = tc_r;

    // Next count and terminal condition assuming this edge is a step.
    always_comb begin
        step_count_s = count_r;
        hit_s        = 1'b0;
        case (mode)
            CNT_DOWN_SAT: begin
                if (count_r == ONE) begin
                    step_count_s = ZERO;
                    hit_s        = 1'b1;
                end else if (count_r == ZERO) begin
                    step_count_s = ZERO;
                end else begin
                    step_count_s = count_r - ONE;
                end
            end
            CNT_DOWN_RELOAD: begin
                if (count_r == ZERO) begin
                    step_count_s = limit_r;
                    hit_s        = 1'b1;
                end else begin
                    step_count_s = count_r - ONE;
                end
            end
            CNT_UP_WRAP: begin
                // count above limit (after a mode switch) rolls over 2^WIDTH naturally
                if (count_r == limit_r) begin
                    step_count_s = ZERO;
                    hit_s        = 1'b1;
                end else begin
                    step_count_s = count_r + ONE;
                end
            end
            CNT_UP_SAT: begin
                // checking >= first also covers limit==0, where limit-1 would alias all-ones
                if (count_r >= limit_r) begin
                    step_count_s = count_r;
                end else if (count_r == (limit_r - ONE)) begin
                    step_count_s = limit_r;
                    hit_s        = 1'b1;
                end else begin
                    step_count_s = count_r + ONE;
                end
            end
            default: begin
                step_count_s = count_r;
                hit_s        = 1'b0;
            end
        endcase
    end

    // Channel state registers: clear > set > step > hold.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            count_r <= ZERO;
            limit_r <= ZERO;
            tc_r    <= 1'b0;
        end else if (clear) begin
            count_r <= ZERO;
            tc_r    <= 1'b0;
        end else if (set) begin
            count_r <= set_val;
            limit_r <= set_val;
            tc_r    <= 1'b0;
        end else if (step_s) begin
            count_r <= step_count_s;
            tc_r    <= hit_s;
        end else begin
            tc_r    <= 1'b0;
        end
    end

endmodule

// File: rtl/multi_counter.sv
// Bank of NUM_CH independent loadable counters with per-channel run modes.
// Define MULTI_COUNTER_CHAIN_EN to gate channel i>0 stepping by channel i-1's terminal event.
module multi_counter
    import counter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_l,
    input  logic [NUM_CH-1:0]             en,
    input  logic [NUM_CH-1:0]             set,
    input  logic [NUM_CH-1:0]             clear,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  set_val,
    input  cnt_mode_t [NUM_CH-1:0]        mode,
    output logic [NUM_CH-1:0][WIDTH-1:0]  count,
    output logic [NUM_CH-1:0][WIDTH-1:0]  limit,
    output logic [NUM_CH-1:0]             tc,
    output logic [NUM_CH-1:0]             zero
);

    logic [NUM_CH-1:0] eff_en_s;

`ifdef MULTI_COUNTER_CHAIN_EN
    logic [NUM_CH-1:0] term_s;

    // term ripples 0 -> NUM_CH-1 in one cycle, so nested loops advance together
    assign eff_en_s[0] = en[0];
    for (genvar i = 1; i < NUM_CH; i++) begin : g_chain
        assign eff_en_s[i] = en[i] & term_s[i-1];
    end
`else
    assign eff_en_s = en;
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        counter_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_l   (rst_l),
            .step_en (eff_en_s[i]),
            .set     (set[i]),
            .clear   (clear[i]),
            .set_val (set_val[i]),
            .mode    (mode[i]),
            .count   (count[i]),
            .limit   (limit[i]),
            .tc      (tc[i]),
`ifdef MULTI_COUNTER_CHAIN_EN
            .term    (term_s[i])
`else
            .term    ()
`endif
        );

        assign zero[i] = (count[i] == {WIDTH{1'b0}});
    end

endmodule
